// File: rtl/cfar_peak_collector.sv
// cfar_peak_collector: per-frame buffer of CFAR detections drained as a valid/ready stream; CFAR_PEAK_MERGE_EN merges adjacent-index detections
module cfar_peak_collector #(
  parameter int INDEX_WIDTH = 10,
  parameter int INPUT_WIDTH = 16,
  parameter int DEPTH       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       max_valid,
  input  logic [INDEX_WIDTH-1:0]     index_in,
  input  logic [INPUT_WIDTH-1:0]     power_in,
  input  logic                       eop_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INDEX_WIDTH-1:0]     out_index,
  output logic [INPUT_WIDTH-1:0]     out_power,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     peak_count,
  output logic                       frame_done,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = INDEX_WIDTH + INPUT_WIDTH;
  typedef enum logic {COLLECT, DRAIN} state_t;
  state_t state, state_next;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, last_addr, wr_addr, load_addr;
  logic [CW-1:0] count_post;
  logic [EW-1:0] load_data;
  logic collect, full, merge, wr_en, drop, xfer, done, start, empty_close, load_last;
`ifdef CFAR_PEAK_MERGE_EN
  logic [EW-1:0] last_entry;
`endif
  // write/merge decision, frame close, and prefetch of the next entry to present
  always_comb begin
    collect = state == COLLECT;
    full = peak_count == CW'(DEPTH);
    last_addr = peak_count[AW-1:0] - 1'b1;
`ifdef CFAR_PEAK_MERGE_EN
    last_entry = mem[last_addr];
    merge = collect && max_valid && peak_count != '0 &&
            (INDEX_WIDTH+1)'(last_entry[EW-1:INPUT_WIDTH]) + 1'b1 == (INDEX_WIDTH+1)'(index_in);
    wr_en = collect && max_valid && (merge ? power_in > last_entry[INPUT_WIDTH-1:0] : !full);
`else
    merge = 1'b0;
    wr_en = collect && max_valid && !full;
`endif
    wr_addr = merge ? last_addr : peak_count[AW-1:0];
    count_post = peak_count + CW'(collect && max_valid && !merge && !full);
    drop = (max_valid && (!collect || (!merge && full))) || (eop_in && !collect);
    xfer = out_valid && out_ready;
    done = xfer && out_last;
    start = collect && eop_in && count_post != '0;
    empty_close = collect && eop_in && count_post == '0;
    load_addr = start ? '0 : rd_ptr + 1'b1;
    load_data = (start && wr_en && wr_addr == '0) ? {index_in, power_in} : mem[load_addr];
    load_last = start ? count_post == CW'(1) : CW'(rd_ptr) + CW'(2) == peak_count;
    state_next = start ? DRAIN : done ? COLLECT : state;
  end
  // detection storage; contents are don't-care until written in the current frame
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {index_in, power_in};
  end
  // frame state, counters and registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      rd_ptr <= '0;
      peak_count <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_index <= '0;
      out_power <= '0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      frame_done <= done || empty_close;
      if (done) begin
        rd_ptr <= '0;
        peak_count <= '0;
        out_valid <= 1'b0;
        out_last <= 1'b0;
        overflow <= 1'b0;
      end else begin
        peak_count <= count_post;
        if (drop) overflow <= 1'b1;
        if (start || xfer) begin
          out_valid <= 1'b1;
          {out_index, out_power} <= load_data;
          out_last <= load_last;
          rd_ptr <= load_addr;
        end
      end
    end
  end
endmodule
